seg_slot_sched: RTL
===================

Name: seg_slot_sched

Overview:
- Schedules active-video pixels into a ring of fixed-size line-buffer slots, one segment (half-line) per slot.
- Issues one descriptor per completed segment, carrying slot and segment index, to the downstream packet builder.
- Sits between the TMDS timing generator (video_en, rx0_vsync) and the slot RAM / packetiser in the rx0_pclk domain.
- Owns slot allocation, release, drop and short-line handling.

Parameters:
- SEG_LEN, 640, pixels per segment.
- SEGS_PER_LINE, 2, segments per active line.
- NSLOTS, 4, slot count; must be a power of 2, ≥2.
- SLOT_W, 2, log2(NSLOTS).
- ADDR_W, 10, pixel address width within a slot; 2^ADDR_W ≥ SEG_LEN.
- IDX_W, 12, segment index width.

Ports:
- rx0_pclk  in  1  pixel clock; all logic on its rising edge.
- rstbtn_n  in  1  asynchronous active-low reset.
- rx0_vsync  in  1  frame sync; high clears line counting.
- video_en  in  1  active-pixel qualifier from the timing block.
- wr_en  out  1  slot RAM write strobe.
- wr_slot  out  SLOT_W  slot being written.
- wr_addr  out  ADDR_W  pixel offset within the slot.
- tx_req  out  1  descriptor valid.
- tx_slot  out  SLOT_W  slot of the offered descriptor.
- tx_idx  out  IDX_W  segment index = line*SEGS_PER_LINE + seg.
- tx_ack  in  1  downstream accepts the descriptor.
- tx_done  in  1  one-cycle pulse: downstream finished reading the in-flight slot.
- free_cnt  out  SLOT_W+1  free slots.
- drop_cnt  out  16  segments dropped because no slot was free; saturates at 0xFFFF.
- err_short  out  1  one-cycle pulse: segment aborted by early video_en fall.

Behaviour:
- Reset (async, rstbtn_n=0):
  - all outputs 0, except free_cnt=NSLOTS.
  - ring pointers 0; line=0, seg=0, pcnt=0; write FSM IDLE, read FSM R_IDLE.
- Registering:
  - all outputs registered.
  - wr_en/wr_slot/wr_addr lag the video_en sample by exactly 1 cycle.
- Write FSM states:
  - IDLE: on video_en=1, if free_cnt>0 allocate slot wptr and go FILL; else go DROP with drop_cnt+1. seg=0, pcnt=0.
  - FILL: each cycle with video_en=1 emits wr_en=1, wr_addr=pcnt, then pcnt+1.
    - At pcnt==SEG_LEN-1: commit (slot enqueued, wptr+1), seg+1, pcnt=0.
    - Next segment allocation happens on the following video_en cycle with the same free check: FILL or DROP.
    - After seg reaches SEGS_PER_LINE, further video_en cycles of the line are ignored (state WAIT).
  - DROP: counts pcnt only, with no wr_en. Segment boundaries are handled as in FILL, but with no commit.
  - WAIT: returns to IDLE when video_en=0.
  - video_en falling in FILL with pcnt≠0 (short line):
    - slot released unconsumed: free_cnt+1, wptr not advanced.
    - err_short pulses 1 cycle; go IDLE.
  - Any video_en fall ends the line: line+1 (wraps at IDX_W), seg=0.
- Line counter:
  - rx0_vsync=1 forces line=0 and aborts any FILL segment, with no err_short.
  - Index wraps modulo 2^IDX_W.
- Read FSM:
  - R_IDLE: when queue non-empty, load head descriptor, assert tx_req and go R_REQ.
    - A descriptor is first visible on tx_req the cycle after its last wr_en.
  - R_REQ: tx_req, tx_slot and tx_idx held stable until tx_ack=1; then tx_req=0, go R_BUSY.
  - R_BUSY: on tx_done, free_cnt+1 and go R_IDLE. tx_done outside R_BUSY is ignored.
- free_cnt arithmetic:
  - allocation −1; release (tx_done or short abort) +1.
  - Simultaneous allocation and release in one cycle: net 0.
  - Never exceeds NSLOTS, never below 0.
- Queue:
  - FIFO of committed slots, in strict commit order.
  - Cannot overflow, because slots are pre-allocated.
- Reset mid-operation:
  - all state cleared immediately.
  - wr_en and tx_req deassert asynchronously.

Test Plan:
- Reset:
  - Stimulus: hold rstbtn_n=0 with video_en toggling.
  - Response: wr_en=0, tx_req=0, free_cnt=4, drop_cnt=0; outputs change with no clock edge.
- Two full lines:
  - Stimulus: rx0_vsync pulse, then two lines of 1280 video_en cycles; tx_ack/tx_done returned promptly.
  - Response: descriptors (slot,idx) = (0,0),(1,1),(2,2),(3,3).
  - Response: wr_addr runs 0..639 per slot; tx_req 1 cycle after wr_addr=639.
- Stall:
  - Stimulus: never assert tx_done; three 1280-cycle lines.
  - Response: slots 0–3 fill; segments 4 and 5 dropped; drop_cnt=2; no wr_en for 1280 cycles; free_cnt=0.
- Short line:
  - Stimulus: 700-cycle video_en.
  - Response: segment 0 committed; segment 1 aborted at pcnt=60; err_short pulses once.
  - Response: free_cnt returns to 3 before tx_done; next line idx=2 uses the released slot 1.
- Simultaneous events:
  - Stimulus: tx_done in the same cycle as a new allocation.
  - Response: free_cnt unchanged.
- Frame restart and reset mid-line:
  - Stimulus: rx0_vsync mid-frame.
  - Response: next descriptor idx=0.
  - Stimulus: rstbtn_n low at pcnt=300.
  - Response: full reset state; no descriptor issued for the partial segment.

Source files
------------

// File: rtl/seg_slot_sched.sv
// seg_slot_sched: allocates half-line segments into a slot ring and queues one descriptor per committed segment
module seg_slot_sched #(
  parameter int SEG_LEN       = 640,
  parameter int SEGS_PER_LINE = 2,
  parameter int NSLOTS        = 4,
  parameter int SLOT_W        = 2,
  parameter int ADDR_W        = 10,
  parameter int IDX_W         = 12
) (
  input  logic              rx0_pclk,
  input  logic              rstbtn_n,
  input  logic              rx0_vsync,
  input  logic              video_en,
  output logic              wr_en,
  output logic [SLOT_W-1:0] wr_slot,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              tx_req,
  output logic [SLOT_W-1:0] tx_slot,
  output logic [IDX_W-1:0]  tx_idx,
  input  logic              tx_ack,
  input  logic              tx_done,
  output logic [SLOT_W:0]   free_cnt,
  output logic [15:0]       drop_cnt,
  output logic              err_short
);
  localparam int SEG_W = $clog2(SEGS_PER_LINE + 1);
  typedef enum logic [1:0] {IDLE, FILL, DROP, WAIT} wst_t;
  typedef enum logic [1:0] {R_IDLE, R_REQ, R_BUSY} rst_t;
  wst_t ws_q, ws_d;
  rst_t rs_q, rs_d;
  logic [ADDR_W-1:0] pcnt_q, pcnt_d, waddr_q;
  logic [SEG_W-1:0] seg_q, seg_d;
  logic [IDX_W-1:0] line_q, line_d, tidx_q, tidx_d, cur_idx;
  logic [SLOT_W-1:0] wptr_q, wptr_d, head_q, head_d, tail, wslot_q, tslot_q, tslot_d;
  logic [SLOT_W:0] qcnt_q, qcnt_d, free_q, free_d;
  logic [15:0] drop_q, drop_d;
  logic ven_q, wr_en_q, wr_en_d, err_q, err_d, treq_q, treq_d;
  logic alloc, rel_w, rel_r, push, pop, fall, seg_end;
  logic [SLOT_W-1:0] q_slot [NSLOTS];
  logic [IDX_W-1:0] q_idx [NSLOTS];
  assign fall    = ven_q && !video_en;
  assign seg_end = pcnt_q == ADDR_W'(SEG_LEN - 1);
  assign cur_idx = IDX_W'(32'(line_q) * SEGS_PER_LINE + 32'(seg_q));
  assign tail    = head_q + qcnt_q[SLOT_W-1:0];
  // Pixel 0 of a segment is written in the same cycle its slot is allocated.
  always_comb begin
    ws_d = ws_q;
    pcnt_d = pcnt_q;
    seg_d = seg_q;
    line_d = line_q;
    wptr_d = wptr_q;
    drop_d = drop_q;
    alloc = 1'b0;
    rel_w = 1'b0;
    push = 1'b0;
    wr_en_d = 1'b0;
    err_d = 1'b0;
    if (rx0_vsync || fall) begin
      ws_d = IDLE;
      pcnt_d = '0;
      seg_d = '0;
      line_d = rx0_vsync ? '0 : line_q + IDX_W'(1);
      rel_w = ws_q == FILL;
      err_d = !rx0_vsync && ws_q == FILL;
    end else if (video_en) begin
      case (ws_q)
        IDLE: begin
          pcnt_d = ADDR_W'(1);
          alloc = free_q != '0;
          wr_en_d = alloc;
          ws_d = alloc ? FILL : DROP;
          drop_d = (alloc || &drop_q) ? drop_q : drop_q + 16'd1;
        end
        FILL, DROP: begin
          wr_en_d = ws_q == FILL;
          pcnt_d = seg_end ? '0 : pcnt_q + ADDR_W'(1);
          if (seg_end) begin
            push = ws_q == FILL;
            wptr_d = wptr_q + SLOT_W'(push);
            seg_d = seg_q + SEG_W'(1);
            ws_d = seg_q == SEG_W'(SEGS_PER_LINE - 1) ? WAIT : IDLE;
          end
        end
        default: ws_d = WAIT;
      endcase
    end
  end
  always_comb begin
    rs_d = rs_q;
    pop = 1'b0;
    rel_r = 1'b0;
    treq_d = treq_q;
    tslot_d = tslot_q;
    tidx_d = tidx_q;
    case (rs_q)
      R_IDLE: if (qcnt_q != '0) begin
        pop = 1'b1;
        treq_d = 1'b1;
        tslot_d = q_slot[head_q];
        tidx_d = q_idx[head_q];
        rs_d = R_REQ;
      end
      R_REQ: if (tx_ack) begin
        treq_d = 1'b0;
        rs_d = R_BUSY;
      end
      R_BUSY: if (tx_done) begin
        rel_r = 1'b1;
        rs_d = R_IDLE;
      end
      default: rs_d = R_IDLE;
    endcase
  end
  assign head_d = head_q + SLOT_W'(pop);
  assign qcnt_d = qcnt_q + {{SLOT_W{1'b0}}, push} - {{SLOT_W{1'b0}}, pop};
  assign free_d = free_q + {{SLOT_W{1'b0}}, rel_w} + {{SLOT_W{1'b0}}, rel_r} - {{SLOT_W{1'b0}}, alloc};
  always_ff @(posedge rx0_pclk)
    if (push) begin
      q_slot[tail] <= wptr_q;
      q_idx[tail] <= cur_idx;
    end
  always_ff @(posedge rx0_pclk or negedge rstbtn_n)
    if (!rstbtn_n) begin
      ws_q <= IDLE;
      rs_q <= R_IDLE;
      pcnt_q <= '0;
      seg_q <= '0;
      line_q <= '0;
      wptr_q <= '0;
      head_q <= '0;
      qcnt_q <= '0;
      free_q <= (SLOT_W + 1)'(NSLOTS);
      drop_q <= '0;
      ven_q <= 1'b0;
      wr_en_q <= 1'b0;
      wslot_q <= '0;
      waddr_q <= '0;
      err_q <= 1'b0;
      treq_q <= 1'b0;
      tslot_q <= '0;
      tidx_q <= '0;
    end else begin
      ws_q <= ws_d;
      rs_q <= rs_d;
      pcnt_q <= pcnt_d;
      seg_q <= seg_d;
      line_q <= line_d;
      wptr_q <= wptr_d;
      head_q <= head_d;
      qcnt_q <= qcnt_d;
      free_q <= free_d;
      drop_q <= drop_d;
      ven_q <= video_en;
      wr_en_q <= wr_en_d;
      wslot_q <= wptr_q;
      waddr_q <= pcnt_q;
      err_q <= err_d;
      treq_q <= treq_d;
      tslot_q <= tslot_d;
      tidx_q <= tidx_d;
    end
  assign wr_en     = wr_en_q;
  assign wr_slot   = wslot_q;
  assign wr_addr   = waddr_q;
  assign tx_req    = treq_q;
  assign tx_slot   = tslot_q;
  assign tx_idx    = tidx_q;
  assign free_cnt  = free_q;
  assign drop_cnt  = drop_q;
  assign err_short = err_q;
endmodule
